// File: rtl/zap_copro_responder_pkg.sv
// zap_copro_responder_pkg: FSM/op encodings, instruction field positions and decode helper
package zap_copro_responder_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_REG_RD, S_REG_WR, S_DONE} state_t;
  typedef enum logic [1:0] {OP_MCR, OP_MRC, OP_CDP, OP_UNDEF} op_t;
  localparam logic [3:0] CP_CLASS = 4'b1110;
  localparam int COND_LSB  = 28;
  localparam int CLASS_LSB = 24;
  localparam int L_BIT     = 20;
  localparam int CRN_LSB   = 16;
  localparam int RD_LSB    = 12;
  localparam int CPNUM_LSB = 8;
  localparam int OPC2_LSB  = 5;
  localparam int B4_BIT    = 4;
  localparam int CRM_LSB   = 0;
  function automatic op_t copro_decode(input logic [3:0] cls, input logic [3:0] cpn,
                                       input logic l, input logic b4, input logic [3:0] cp_num);
    return (cls != CP_CLASS || cpn != cp_num) ? OP_UNDEF : !b4 ? OP_CDP : l ? OP_MRC : OP_MCR;
  endfunction
endpackage

// File: rtl/zap_copro_responder_if.sv
// zap_copro_responder_if: coprocessor instruction handshake plus core register-file port
interface zap_copro_responder_if;
  logic        i_copro_dav;
  logic [31:0] i_copro_word;
  logic        o_copro_done;
  logic        o_copro_undef;
  logic        o_reg_req;
  logic        o_reg_wr;
  logic [3:0]  o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic [31:0] i_reg_rdata;
  logic        i_reg_ack;
  modport master (output i_copro_dav, i_copro_word, i_reg_rdata, i_reg_ack,
                  input o_copro_done, o_copro_undef, o_reg_req, o_reg_wr, o_reg_addr, o_reg_wdata);
  modport slave (input i_copro_dav, i_copro_word, i_reg_rdata, i_reg_ack,
                 output o_copro_done, o_copro_undef, o_reg_req, o_reg_wr, o_reg_addr, o_reg_wdata);
endinterface

// File: rtl/zap_copro_regbank.sv
// zap_copro_regbank: CP register bank, one write port, async read; ZAP_COPRO_ID_REG_EN makes CRn=0 a read-only ID
module zap_copro_regbank #(
  parameter int          NUM_CP_REGS = 16,
  parameter logic [31:0] ID_VALUE    = 32'h4107_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_raddr,
  output logic [31:0] o_rdata
);
`ifdef ZAP_COPRO_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  logic [31:0] r_regs [NUM_CP_REGS];
  logic        w_wr_ok;
  logic        w_rd_ok;
  assign w_wr_ok = i_we && (32'(i_waddr) < NUM_CP_REGS) && !(ID_EN && i_waddr == 4'd0);
  assign w_rd_ok = 32'(i_raddr) < NUM_CP_REGS;
  assign o_rdata = (ID_EN && i_raddr == 4'd0) ? ID_VALUE : w_rd_ok ? r_regs[i_raddr] : 32'd0;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n)
      for (int i = 0; i < NUM_CP_REGS; i++) r_regs[i] <= '0;
    else if (w_wr_ok)
      r_regs[i_waddr] <= i_wdata;
endmodule

// File: rtl/zap_copro_responder.sv
// zap_copro_responder: MCR/MRC/CDP coprocessor responder FSM; ZAP_COPRO_ID_REG_EN enables the read-only ID at CRn=0
module zap_copro_responder
  import zap_copro_responder_pkg::*;
#(
  parameter logic [3:0]  CP_NUM      = 4'd15,
  parameter int          NUM_CP_REGS = 16,
  parameter logic [31:0] ID_VALUE    = 32'h4107_0000
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  zap_copro_responder_if.slave bus
);
  state_t      r_state, w_state;
  op_t         r_op, w_op;
  logic [3:0]  r_crn, w_crn, r_rd, w_rd, r_addr, w_addr;
  logic        r_done, w_done, r_undef, w_undef, r_req, w_req, r_wr, w_wr;
  logic        w_we, w_unused;
  logic [31:0] r_wdata, w_wdata, w_cp_rdata;
  // condition, opc2 and CRm play no part in this responder's behaviour
  assign w_unused = ^{bus.i_copro_word[COND_LSB +: 4], bus.i_copro_word[OPC2_LSB +: 3],
                      bus.i_copro_word[CRM_LSB +: 4]};
  zap_copro_regbank #(.NUM_CP_REGS(NUM_CP_REGS), .ID_VALUE(ID_VALUE)) u_regbank (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_we     (w_we),
    .i_waddr  (r_crn),
    .i_wdata  (bus.i_reg_rdata),
    .i_raddr  (r_crn),
    .o_rdata  (w_cp_rdata)
  );
  always_comb begin
    w_state = r_state;
    w_op    = r_op;
    w_crn   = r_crn;
    w_rd    = r_rd;
    w_done  = r_done;
    w_undef = r_undef;
    w_req   = r_req;
    w_wr    = r_wr;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_we    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.i_copro_dav) begin
        w_state = S_DECODE;
        w_op    = copro_decode(bus.i_copro_word[CLASS_LSB +: 4], bus.i_copro_word[CPNUM_LSB +: 4],
                               bus.i_copro_word[L_BIT], bus.i_copro_word[B4_BIT], CP_NUM);
        w_crn   = bus.i_copro_word[CRN_LSB +: 4];
        w_rd    = bus.i_copro_word[RD_LSB +: 4];
      end
      S_DECODE: if (!bus.i_copro_dav) w_state = S_IDLE;
      else begin
        w_state = r_op == OP_MCR ? S_REG_RD : r_op == OP_MRC ? S_REG_WR : S_DONE;
        w_req   = r_op inside {OP_MCR, OP_MRC};
        w_wr    = r_op == OP_MRC;
        w_addr  = r_rd;
        w_wdata = r_op == OP_MRC ? w_cp_rdata : r_wdata;
        w_done  = r_op inside {OP_CDP, OP_UNDEF};
        w_undef = r_op == OP_UNDEF;
      end
      S_REG_RD, S_REG_WR: if (!bus.i_copro_dav) begin
        w_state = S_IDLE;
        w_req   = 1'b0;
        w_wr    = 1'b0;
      end else if (bus.i_reg_ack) begin
        w_state = S_DONE;
        w_req   = 1'b0;
        w_wr    = 1'b0;
        w_done  = 1'b1;
        w_we    = r_state == S_REG_RD;
      end
      S_DONE: if (!bus.i_copro_dav) begin
        w_state = S_IDLE;
        w_done  = 1'b0;
        w_undef = 1'b0;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_UNDEF;
      r_crn   <= '0;
      r_rd    <= '0;
      r_done  <= 1'b0;
      r_undef <= 1'b0;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state;
      r_op    <= w_op;
      r_crn   <= w_crn;
      r_rd    <= w_rd;
      r_done  <= w_done;
      r_undef <= w_undef;
      r_req   <= w_req;
      r_wr    <= w_wr;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  assign bus.o_copro_done  = r_done;
  assign bus.o_copro_undef = r_undef;
  assign bus.o_reg_req     = r_req;
  assign bus.o_reg_wr      = r_wr;
  assign bus.o_reg_addr    = r_addr;
  assign bus.o_reg_wdata   = r_wdata;
endmodule

// File: tb/tb_zap_copro_responder.sv
// tb_zap_copro_responder: randomized scoreboard bench against a behavioural coprocessor model
module tb_zap_copro_responder;
  localparam logic [31:0] ID_VALUE = 32'h4107_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  zap_copro_responder_if bus();
  zap_copro_responder dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
  typedef struct {logic wr; logic [3:0] addr; logic [31:0] wdata;} req_t;
  typedef struct {logic undef; int due;} done_t;
  req_t        q_req[$];
  done_t       q_done[$];
  req_t        cur;
  done_t       dexp;
  logic [31:0] model [16];
  int          total = 0, bad = 0, cyc = 0, cur_delay = 0;
  logic [31:0] cur_rdata = 0;
  logic        prev_req = 0, prev_done = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // 0=MCR 1=MRC 2=CDP 3=UNDEF, straight from the instruction encoding rules
  function automatic int model_op(input logic [31:0] w);
    if (w[27:24] != 4'hE || w[11:8] != 4'd15) return 3;
    if (!w[4]) return 2;
    return w[20] ? 1 : 0;
  endfunction
  function automatic logic [31:0] m_read(input logic [3:0] crn);
`ifdef ZAP_COPRO_ID_REG_EN
    if (crn == 4'd0) return ID_VALUE;
`endif
    return model[crn];
  endfunction
  function automatic void m_write(input logic [3:0] crn, input logic [31:0] d);
`ifdef ZAP_COPRO_ID_REG_EN
    if (crn == 4'd0) return;
`endif
    model[crn] = d;
  endfunction
  always @(posedge clk) cyc++;
  initial begin
    int cnt;
    cnt = 0;
    bus.i_reg_ack = 1'b0;
    bus.i_reg_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.o_reg_req) begin
        bus.i_reg_ack = (cnt == cur_delay);
        bus.i_reg_rdata = (cnt == cur_delay) ? cur_rdata : $urandom;
        cnt++;
      end else begin
        bus.i_reg_ack = ($urandom_range(0, 5) == 0);
        bus.i_reg_rdata = $urandom;
        cnt = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (bus.o_reg_req && !prev_req) begin
      if (q_req.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got reg request addr=%h expected none", bus.o_reg_addr);
      end else begin
        cur = q_req.pop_front();
        check("req_wr", bus.o_reg_wr, cur.wr);
        check("req_addr", bus.o_reg_addr, cur.addr);
        if (cur.wr) check("req_wdata", bus.o_reg_wdata, cur.wdata);
      end
    end else if (bus.o_reg_req) begin
      check("req_stable_addr", bus.o_reg_addr, cur.addr);
      check("req_stable_wr", bus.o_reg_wr, cur.wr);
    end
    if (bus.o_copro_done && !prev_done) begin
      if (q_done.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        dexp = q_done.pop_front();
        check("done_undef", bus.o_copro_undef, dexp.undef);
        check("done_latency", cyc, dexp.due);
      end
    end
    prev_req = bus.o_reg_req;
    prev_done = bus.o_copro_done;
  end
  task automatic txn(input logic [31:0] w, input logic [31:0] rdata, input int delay,
                     input int hold, input bit flush_in);
    int op;
    bit flush;
    req_t r;
    done_t d;
    op = model_op(w);
    flush = flush_in && op <= 1;
    cur_rdata = rdata;
    cur_delay = delay;
    if (op <= 1) begin
      r.wr = (op == 1);
      r.addr = w[15:12];
      r.wdata = (op == 1) ? m_read(w[19:16]) : 32'd0;
      q_req.push_back(r);
    end
    if (!flush) begin
      d.undef = (op == 3);
      d.due = cyc + ((op <= 1) ? 3 + delay : 2);
      q_done.push_back(d);
      if (op == 0) m_write(w[19:16], rdata);
    end
    bus.i_copro_word = w;
    bus.i_copro_dav = 1'b1;
    if (flush) begin
      for (int t = 0; t < 20 && !bus.o_reg_req; t++) @(negedge clk);
      check("flush_req_seen", bus.o_reg_req, 1);
      bus.i_copro_dav = 1'b0;
      @(negedge clk);
      check("flush_req_drop", bus.o_reg_req, 0);
      check("flush_no_done", bus.o_copro_done, 0);
    end else begin
      for (int t = 0; t < 60 && !bus.o_copro_done; t++) @(negedge clk);
      check("done_seen", bus.o_copro_done, 1);
      repeat (hold) begin
        @(negedge clk);
        check("done_hold", bus.o_copro_done, 1);
      end
      bus.i_copro_dav = 1'b0;
      @(negedge clk);
      check("done_drop", {bus.o_copro_done, bus.o_copro_undef}, 0);
    end
  endtask
  task automatic check_outputs_zero(input string name);
    check(name, {bus.o_copro_done, bus.o_copro_undef, bus.o_reg_req, bus.o_reg_wr}, 0);
    check(name, bus.o_reg_addr, 0);
    check(name, bus.o_reg_wdata, 0);
  endtask
  task automatic reset_mid();
    req_t r;
    r.wr = 1'b1;
    r.addr = 4'd1;
    r.wdata = m_read(4'd1);
    q_req.push_back(r);
    cur_delay = 1000;
    bus.i_copro_word = 32'hEE11_1F10;
    bus.i_copro_dav = 1'b1;
    for (int t = 0; t < 20 && !bus.o_reg_req; t++) @(negedge clk);
    check("rst_req_seen", bus.o_reg_req, 1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset_outputs");
    bus.i_copro_dav = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_delay = 0;
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] w;
    bus.i_copro_dav = 1'b0;
    bus.i_copro_word = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(32'hEE01_0F10, 32'hDEAD_BEEF, 0, 0, 0);
    txn(32'hEE11_1F10, 32'h0, 0, 3, 0);
    txn(32'hEE01_0E10, 32'h0, 0, 0, 0);
    txn(32'hEE01_0F00, 32'h0, 0, 1, 0);
    txn(32'hEE03_2F10, 32'h1234_5678, 5, 0, 0);
    txn(32'hEE13_2F10, 32'h0, 0, 0, 0);
    txn(32'hEE05_2F10, 32'hCAFE_F00D, 0, 0, 1);
    txn(32'hEE15_2F10, 32'h0, 0, 0, 0);
    txn(32'hEE00_0F10, 32'h5555_AAAA, 1, 0, 0);
    txn(32'hEE10_3F10, 32'h0, 0, 0, 0);
    reset_mid();
    txn(32'hEE11_1F10, 32'h0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[27:24] = 4'hE;
      if ($urandom_range(0, 9) < 8) w[11:8] = 4'hF;
      if ($urandom_range(0, 9) < 7) w[4] = 1'b1;
      txn(w, $urandom, $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 9) == 0);
    end
    repeat (3) @(negedge clk);
    check("queues_drained", q_req.size() + q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
